// File: rtl/tip_hello_axi_pkg.sv
// Shared types and constants for the AXI burst initiator:
// FSM state encoding, AXI burst/resp encodings, 4 KB window.
package tip_hello_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_FIN
    } state_e;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [31:0] AXI_4K_LIMIT = 32'd4096;

    // True when a burst starting at page offset off with len+1 beats
    // of nbytes each would run past the end of its 4 KB page.
    function automatic logic crosses_4k(
        input logic [11:0]           off,
        input logic [AXI_LEN_W-1:0]  len,
        input logic [31:0]           nbytes
    );
        logic [31:0] span;
        span = 32'(off) + (32'(len) + 32'd1) * nbytes;
        return span > AXI_4K_LIMIT;
    endfunction

endpackage

// File: rtl/tip_hello_axi_beat_counter.sv
// Beat counter shared by the W and R data phases.
// Ports: clk/rst, clr_i (restart at beat 0), inc_i (advance one beat),
// len_i (beats minus 1), last_o (current beat is beat len_i).
module tip_hello_axi_beat_counter
    import tip_hello_axi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic [AXI_LEN_W-1:0] len_i,
    output logic                 last_o
);

    logic [AXI_LEN_W-1:0] cnt_q;
    logic [AXI_LEN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/tip_hello_axi_burst_initiator.sv
// Single-outstanding AXI burst initiator: one command in, one INCR burst
// out (write: AW/W/B, read: AR/R), done pulse with sticky error flag.
// Ports: clk/rst; cmd_* command handshake; wsrc_* write stream in;
// rdst_* read stream out; done/done_error status; sxaw/sxw/sxb/sxar/sxr
// AXI master channels.
// Optional: define TIP_HELLO_AXI_INIT_TIMEOUT_EN to add a B/R response
// timeout of TIMEOUT_CYCLES cycles.
module tip_hello_axi_burst_initiator
    import tip_hello_axi_pkg::*;
#(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_AXI_TID = 4,
    parameter int TID_VALUE  = 0
`ifdef TIP_HELLO_AXI_INIT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [BW_ADDR-1:0]     cmd_addr,
    input  logic [AXI_LEN_W-1:0]   cmd_len,

    input  logic [BW_DATA-1:0]     wsrc_data,
    input  logic                   wsrc_valid,
    output logic                   wsrc_ready,

    output logic [BW_DATA-1:0]     rdst_data,
    output logic                   rdst_valid,
    input  logic                   rdst_ready,

    output logic                   done,
    output logic                   done_error,

    output logic [BW_AXI_TID-1:0]  sxawid,
    output logic [BW_ADDR-1:0]     sxawaddr,
    output logic [AXI_LEN_W-1:0]   sxawlen,
    output logic [AXI_SIZE_W-1:0]  sxawsize,
    output logic [AXI_BURST_W-1:0] sxawburst,
    output logic                   sxawvalid,
    input  logic                   sxawready,

    output logic [BW_AXI_TID-1:0]  sxwid,
    output logic [BW_DATA-1:0]     sxwdata,
    output logic [BW_DATA/8-1:0]   sxwstrb,
    output logic                   sxwlast,
    output logic                   sxwvalid,
    input  logic                   sxwready,

    input  logic [BW_AXI_TID-1:0]  sxbid,
    input  logic [AXI_RESP_W-1:0]  sxbresp,
    input  logic                   sxbvalid,
    output logic                   sxbready,

    output logic [BW_AXI_TID-1:0]  sxarid,
    output logic [BW_ADDR-1:0]     sxaraddr,
    output logic [AXI_LEN_W-1:0]   sxarlen,
    output logic [AXI_SIZE_W-1:0]  sxarsize,
    output logic [AXI_BURST_W-1:0] sxarburst,
    output logic                   sxarvalid,
    input  logic                   sxarready,

    input  logic [BW_AXI_TID-1:0]  sxrid,
    input  logic [BW_DATA-1:0]     sxrdata,
    input  logic [AXI_RESP_W-1:0]  sxrresp,
    input  logic                   sxrlast,
    input  logic                   sxrvalid,
    output logic                   sxrready
);

    localparam int          BYTES     = BW_DATA / 8;
    localparam int          SIZE_LOG2 = $clog2(BYTES);
    localparam logic [31:0] BYTES_U   = 32'(BYTES);

    state_e               state_q, state_d;
    logic [BW_ADDR-1:0]   addr_q, addr_d;
    logic [AXI_LEN_W-1:0] len_q, len_d;
    logic                 err_q, err_d;

    logic bc_clr;
    logic bc_inc;
    logic bc_last;
    logic tmo;
    logic cmd_bad;

    // Response IDs are not checked; the single outstanding burst
    // makes every response belong to it.
    logic unused_ids;
    assign unused_ids = ^{sxbid, sxrid};

    assign cmd_bad = (|cmd_addr[SIZE_LOG2-1:0]) ||
                     crosses_4k(cmd_addr[11:0], cmd_len, BYTES_U);

    tip_hello_axi_beat_counter u_beats (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (bc_clr),
        .inc_i  (bc_inc),
        .len_i  (len_q),
        .last_o (bc_last)
    );

`ifdef TIP_HELLO_AXI_INIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_wait;
    logic             tmo_hs;

    assign tmo_wait = (state_q == ST_B) || (state_q == ST_R);
    assign tmo_hs   = (sxbvalid && sxbready) || (sxrvalid && sxrready);

    // Counts cycles spent waiting for the next B/R beat; zero outside
    // B/R so entry into B/R starts a fresh window.
    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (!tmo_wait || tmo_hs) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_wait && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        err_d      = err_q;
        cmd_ready  = 1'b0;
        sxawvalid  = 1'b0;
        sxarvalid  = 1'b0;
        sxwvalid   = 1'b0;
        wsrc_ready = 1'b0;
        sxbready   = 1'b0;
        sxrready   = 1'b0;
        rdst_valid = 1'b0;
        done       = 1'b0;
        done_error = 1'b0;
        bc_clr     = 1'b0;
        bc_inc     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                bc_clr    = 1'b1;
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    err_d  = cmd_bad;
                    if (cmd_bad) begin
                        state_d = ST_FIN;
                    end else if (cmd_write) begin
                        state_d = ST_AW;
                    end else begin
                        state_d = ST_AR;
                    end
                end
            end
            ST_AW: begin
                sxawvalid = 1'b1;
                if (sxawready) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                sxwvalid   = wsrc_valid;
                wsrc_ready = sxwready;
                if (wsrc_valid && sxwready) begin
                    if (bc_last) begin
                        state_d = ST_B;
                    end else begin
                        bc_inc = 1'b1;
                    end
                end
            end
            ST_B: begin
                sxbready = !tmo;
                if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (sxbvalid) begin
                    if (sxbresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_FIN;
                end
            end
            ST_AR: begin
                sxarvalid = 1'b1;
                if (sxarready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                rdst_valid = sxrvalid && !tmo;
                sxrready   = rdst_ready && !tmo;
                if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (sxrvalid && rdst_ready) begin
                    if (sxrresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    // A last flag on the wrong beat in either direction
                    // is a length mismatch with the slave.
                    if (sxrlast != bc_last) begin
                        err_d = 1'b1;
                    end
                    if (sxrlast) begin
                        state_d = ST_FIN;
                    end else begin
                        bc_inc = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                done_error = err_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign sxawid    = BW_AXI_TID'(TID_VALUE);
    assign sxawaddr  = addr_q;
    assign sxawlen   = len_q;
    assign sxawsize  = AXI_SIZE_W'(SIZE_LOG2);
    assign sxawburst = AXI_BURST_INCR;

    assign sxarid    = BW_AXI_TID'(TID_VALUE);
    assign sxaraddr  = addr_q;
    assign sxarlen   = len_q;
    assign sxarsize  = AXI_SIZE_W'(SIZE_LOG2);
    assign sxarburst = AXI_BURST_INCR;

    assign sxwid     = BW_AXI_TID'(TID_VALUE);
    assign sxwdata   = wsrc_data;
    assign sxwstrb   = '1;
    assign sxwlast   = bc_last;

    assign rdst_data = sxrdata;

endmodule

// File: tb/tb_tip_hello_axi_burst_initiator.sv
// Self-checking bench for tip_hello_axi_burst_initiator: directed table,
// randomized commands against a transaction-level model, reset corner.
module tb_tip_hello_axi_burst_initiator;

    localparam int BW_ADDR = 32;
    localparam int BW_DATA = 32;
    localparam int BW_TID  = 4;
`ifdef TIP_HELLO_AXI_INIT_TIMEOUT_EN
    localparam int PMIN = 90;
`else
    localparam int PMIN = 30;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                cmd_valid, cmd_ready, cmd_write;
    logic [BW_ADDR-1:0]  cmd_addr;
    logic [7:0]          cmd_len;
    logic [BW_DATA-1:0]  wsrc_data;
    logic                wsrc_valid, wsrc_ready;
    logic [BW_DATA-1:0]  rdst_data;
    logic                rdst_valid, rdst_ready;
    logic                done, done_error;
    logic [BW_TID-1:0]   sxawid, sxwid, sxbid, sxarid, sxrid;
    logic [BW_ADDR-1:0]  sxawaddr, sxaraddr;
    logic [7:0]          sxawlen, sxarlen;
    logic [2:0]          sxawsize, sxarsize;
    logic [1:0]          sxawburst, sxarburst, sxbresp, sxrresp;
    logic                sxawvalid, sxawready, sxarvalid, sxarready;
    logic [BW_DATA-1:0]  sxwdata, sxrdata;
    logic [BW_DATA/8-1:0] sxwstrb;
    logic                sxwlast, sxwvalid, sxwready;
    logic                sxbvalid, sxbready;
    logic                sxrlast, sxrvalid, sxrready;

    tip_hello_axi_burst_initiator #(
        .BW_ADDR    (BW_ADDR),
        .BW_DATA    (BW_DATA),
        .BW_AXI_TID (BW_TID),
        .TID_VALUE  (0)
`ifdef TIP_HELLO_AXI_INIT_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_write (cmd_write), .cmd_addr (cmd_addr), .cmd_len (cmd_len),
        .wsrc_data (wsrc_data), .wsrc_valid (wsrc_valid),
        .wsrc_ready (wsrc_ready),
        .rdst_data (rdst_data), .rdst_valid (rdst_valid),
        .rdst_ready (rdst_ready),
        .done (done), .done_error (done_error),
        .sxawid (sxawid), .sxawaddr (sxawaddr), .sxawlen (sxawlen),
        .sxawsize (sxawsize), .sxawburst (sxawburst),
        .sxawvalid (sxawvalid), .sxawready (sxawready),
        .sxwid (sxwid), .sxwdata (sxwdata), .sxwstrb (sxwstrb),
        .sxwlast (sxwlast), .sxwvalid (sxwvalid), .sxwready (sxwready),
        .sxbid (sxbid), .sxbresp (sxbresp), .sxbvalid (sxbvalid),
        .sxbready (sxbready),
        .sxarid (sxarid), .sxaraddr (sxaraddr), .sxarlen (sxarlen),
        .sxarsize (sxarsize), .sxarburst (sxarburst),
        .sxarvalid (sxarvalid), .sxarready (sxarready),
        .sxrid (sxrid), .sxrdata (sxrdata), .sxrresp (sxrresp),
        .sxrlast (sxrlast), .sxrvalid (sxrvalid), .sxrready (sxrready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int prdy   = 100;
    bit b_never = 1'b0;
    int b_entry = 0;
    int done_at = 0;

    typedef struct {
        string       tag;
        bit          wr;
        logic [31:0] addr;
        int          len;
        int          err_beat;
        int          nret;
        int          rdy;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h",
                     name, act, exp);
        end
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a,
                                            input int i);
        return (a * 32'h9E37) ^ (32'(i) << 8) ^ 32'h5A00_00C3;
    endfunction

    function automatic logic [31:0] wr_word(input logic [31:0] base,
                                            input int i);
        return base + 32'(i) * 32'h0101_0103;
    endfunction

    // Command is rejected if misaligned or its bytes leave the 4 KB page.
    function automatic bit model_bad(input logic [31:0] a, input int len);
        int off;
        off = int'(a % 4096);
        return (a % 4 != 0) || (off + (len + 1) * 4 > 4096);
    endfunction

    function automatic bit model_err(input bit wr, input logic [31:0] a,
                                     input int len, input int err_beat,
                                     input int nret);
        if (model_bad(a, len)) return 1'b1;
        if (wr) return err_beat >= 0;
        if (nret != len + 1) return 1'b1;
        return (err_beat >= 0) && (err_beat < nret);
    endfunction

    task automatic idle_inputs();
        cmd_valid  = 1'b0;
        wsrc_valid = 1'b0;
        rdst_ready = 1'b0;
        sxawready  = 1'b0;
        sxwready   = 1'b0;
        sxbvalid   = 1'b0;
        sxarready  = 1'b0;
        sxrvalid   = 1'b0;
        sxrlast    = 1'b0;
        sxbresp    = 2'b00;
        sxrresp    = 2'b00;
    endtask

    task automatic run_cmd(input string tag, input bit wr,
                           input logic [31:0] addr, input int len,
                           input int err_beat, input int nret_in,
                           input bit exp_err);
        int nret;
        bit bad;
        logic [31:0] wbase;
        int aw_n, ar_n, w_n, r_n, src_n, rs_n;
        int bad_pl, bad_w, bad_r, viol, acc_cyc, ndone;
        bit got_done, b_done, hs_cmd, hs_src, hs_b, hs_r;
        bit aw_pend, ar_pend;
        logic [31:0] aw_prev, ar_prev;
        logic done_err_v;
        nret  = (nret_in > 0) ? nret_in : len + 1;
        bad   = model_bad(addr, len);
        wbase = $urandom;
        aw_n = 0; ar_n = 0; w_n = 0; r_n = 0; src_n = 0; rs_n = 0;
        bad_pl = 0; bad_w = 0; bad_r = 0; viol = 0;
        acc_cyc = -100; ndone = 0; done_err_v = 1'bx;
        got_done = 0; b_done = 0; aw_pend = 0; ar_pend = 0;
        aw_prev = '0; ar_prev = '0;
        if (prdy < PMIN) prdy = PMIN;

        @(posedge clk); #1;
        idle_inputs();
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = 8'(len);

        for (int k = 0; k < 4000 && !got_done; k++) begin
            @(negedge clk);
            hs_cmd = cmd_valid && cmd_ready;
            if (hs_cmd) acc_cyc = cyc;
            if (aw_pend && (!sxawvalid || sxawaddr !== aw_prev)) viol++;
            if (ar_pend && (!sxarvalid || sxaraddr !== ar_prev)) viol++;
            if (sxawvalid) begin
                if (sxawaddr !== addr || sxawlen !== 8'(len) ||
                    sxawsize !== 3'd2 || sxawburst !== 2'b01 ||
                    sxawid !== 4'd0) bad_pl++;
                if (sxawready) aw_n++;
            end
            if (sxarvalid) begin
                if (sxaraddr !== addr || sxarlen !== 8'(len) ||
                    sxarsize !== 3'd2 || sxarburst !== 2'b01 ||
                    sxarid !== 4'd0) bad_pl++;
                if (sxarready) ar_n++;
            end
            aw_pend = sxawvalid && !sxawready;
            ar_pend = sxarvalid && !sxarready;
            aw_prev = sxawaddr;
            ar_prev = sxaraddr;
            if (sxwvalid && sxwready) begin
                if (sxwdata !== wr_word(wbase, w_n) ||
                    sxwlast !== (w_n == len) ||
                    sxwstrb !== 4'hF || sxwid !== 4'd0) bad_w++;
                if (w_n == len) b_entry = cyc + 1;
                w_n++;
            end
            if (rdst_valid && rdst_ready) begin
                if (rdst_data !== rd_word(addr, r_n)) bad_r++;
                r_n++;
            end
            hs_src = wsrc_valid && wsrc_ready;
            hs_b   = sxbvalid && sxbready;
            hs_r   = sxrvalid && sxrready;
            if (done) begin
                got_done   = 1'b1;
                done_at    = cyc;
                done_err_v = done_error;
            end
            @(posedge clk); #1;
            if (hs_cmd) cmd_valid = 1'b0;
            if (hs_src) src_n++;
            if (hs_b) b_done = 1'b1;
            if (hs_r) rs_n++;
            sxawready  = rnd(prdy);
            sxarready  = rnd(prdy);
            sxwready   = rnd(prdy);
            rdst_ready = rnd(prdy);
            if (src_n > len) begin
                wsrc_valid = 1'b0;
            end else if (!wsrc_valid || hs_src) begin
                wsrc_valid = rnd(prdy);
                wsrc_data  = wr_word(wbase, src_n);
            end
            if (w_n == len + 1 && !b_done && !b_never) begin
                if (!sxbvalid) sxbvalid = rnd(prdy);
                sxbresp = (err_beat >= 0) ? 2'b10 : 2'b00;
            end else begin
                sxbvalid = 1'b0;
            end
            if (ar_n > 0 && rs_n < nret) begin
                if (!sxrvalid || hs_r) begin
                    sxrvalid = rnd(prdy);
                    sxrdata  = rd_word(addr, rs_n);
                    sxrresp  = (rs_n == err_beat) ? 2'b10 : 2'b00;
                    sxrlast  = (rs_n == nret - 1);
                end
            end else begin
                sxrvalid = 1'b0;
            end
        end

        chk({tag, ".done_seen"}, 64'(got_done), 64'd1);
        chk({tag, ".done_error"}, 64'(done_err_v), 64'(exp_err));
        chk({tag, ".handshake_stable"}, 64'(viol), 64'd0);
        if (bad) begin
            chk({tag, ".no_bus"}, 64'(aw_n + ar_n + w_n), 64'd0);
            chk({tag, ".done_latency"}, 64'(done_at - acc_cyc), 64'd1);
        end else if (wr) begin
            chk({tag, ".aw_count"}, 64'(aw_n), 64'd1);
            chk({tag, ".ar_count"}, 64'(ar_n), 64'd0);
            chk({tag, ".w_beats"}, 64'(w_n), 64'(len + 1));
            chk({tag, ".w_payload_errs"}, 64'(bad_w), 64'd0);
            chk({tag, ".aw_payload_errs"}, 64'(bad_pl), 64'd0);
        end else begin
            chk({tag, ".ar_count"}, 64'(ar_n), 64'd1);
            chk({tag, ".aw_count"}, 64'(aw_n), 64'd0);
            chk({tag, ".r_beats"}, 64'(r_n), 64'(nret));
            chk({tag, ".r_data_errs"}, 64'(bad_r), 64'd0);
            chk({tag, ".ar_payload_errs"}, 64'(bad_pl), 64'd0);
        end
        idle_inputs();
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, ".ready_after"}, 64'(cmd_ready), 64'd1);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic [31:0] a;
        int len, off, eb, nr;
        bit wr;

        idle_inputs();
        cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wsrc_data = '0; sxbid = '0; sxrid = '0; sxrdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.valids",
            64'({sxawvalid, sxwvalid, sxarvalid, sxbready, sxrready,
                 rdst_valid, wsrc_ready, done, done_error}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset.cmd_ready", 64'(cmd_ready), 64'd1);

        vecs.push_back('{"wr100_len3", 1, 32'h100, 3, -1, 0, 100, 0});
        vecs.push_back('{"rd200_len7", 0, 32'h200, 7, -1, 0, 50, 0});
        vecs.push_back('{"wrFF8_cross", 1, 32'hFF8, 3, -1, 0, 100, 1});
        vecs.push_back('{"rd300_slverr", 0, 32'h300, 3, 2, 0, 70, 1});
        vecs.push_back('{"wrFF0_edge", 1, 32'hFF0, 3, -1, 0, 80, 0});
        vecs.push_back('{"rd1FF4_cross", 0, 32'h1FF4, 3, -1, 0, 80, 1});
        vecs.push_back('{"wr102_misal", 1, 32'h102, 0, -1, 0, 80, 1});
        vecs.push_back('{"rd400_early", 0, 32'h400, 5, -1, 3, 80, 1});
        vecs.push_back('{"wr500_bresp", 1, 32'h500, 2, 0, 0, 80, 1});
        vecs.push_back('{"rd000_len0", 0, 32'h0, 0, -1, 0, 60, 0});
        vecs.push_back('{"wrC00_len255", 1, 32'hC00, 255, -1, 0, 90, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            prdy = v.rdy;
            run_cmd(v.tag, v.wr, v.addr, v.len, v.err_beat, v.nret,
                    v.exp_err);
        end

        for (int i = 0; i < 40; i++) begin
            wr  = rnd(50);
            len = $urandom_range(15, 0);
            off = 4 * $urandom_range(1023, 0);
            if (rnd(25)) off = 4096 - (len + 1) * 4 + 4 * $urandom_range(2, 0) - 4;
            if (off < 0) off = 0;
            a = {18'($urandom_range(7, 0)), 14'(0)} + 32'(off);
            if (rnd(10)) a = a + 32'($urandom_range(3, 1));
            eb = rnd(25) ? $urandom_range(len + 1, 0) : -1;
            nr = (!wr && len > 0 && rnd(15)) ? $urandom_range(len, 1) : 0;
            prdy = $urandom_range(100, PMIN);
            run_cmd($sformatf("rand%0d", i), wr, a, len, eb, nr,
                    model_err(wr, a, len, eb, nr == 0 ? len + 1 : nr));
        end

        // Reset in the middle of a write burst, during beat 1.
        @(posedge clk); #1;
        idle_inputs();
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 32'h100; cmd_len = 8'd3;
        sxawready = 1'b1; sxwready = 1'b1;
        wsrc_valid = 1'b1; wsrc_data = 32'hCAFE_0000;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid.w_beat0", 64'(sxwvalid && sxwready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wsrc_valid = 1'b0;
        @(negedge clk);
        chk("rstmid.valids",
            64'({sxawvalid, sxwvalid, sxarvalid, sxbready, rdst_valid,
                 wsrc_ready, done}), 64'd0);
        chk("rstmid.cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        chk("rstmid.no_done", 64'(done), 64'd0);
        idle_inputs();

`ifdef TIP_HELLO_AXI_INIT_TIMEOUT_EN
        prdy = 100;
        b_never = 1'b1;
        run_cmd("tmo_b", 1, 32'h800, 3, -1, 0, 1);
        chk("tmo_b.latency", 64'(done_at - b_entry), 64'd16);
        b_never = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
